// File: rtl/score_text_writer_if.sv
// Request side (score/update/busy/done) and text-RAM write side of the score
// text writer, bundled so game logic, writer and RAM share one connection.
interface score_text_writer_if #(
  parameter int BIN_W  = 17,
  parameter int ADDR_W = 8
);
  logic [BIN_W-1:0]  score;
  logic              update;
  logic [7:0]        data_In;
  logic [ADDR_W-1:0] write_address;
  logic              we;
  logic              busy;
  logic              done;

  modport master (
    output score, update,
    input  data_In, write_address, we, busy, done
  );

  modport slave (
    input  score, update,
    output data_In, write_address, we, busy, done
  );
endinterface

// File: rtl/score_text_writer.sv
// Renders "SCORE " plus a blank-padded decimal score into the HUD text RAM,
// converting binary to BCD with an iterative shift-and-add-3.
module score_text_writer #(
  parameter int BIN_W      = 17,
  parameter int NUM_DIGITS = 5,
  parameter int ROW        = 0,
  parameter int COL        = 0,
  parameter int ADDR_W     = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  score_text_writer_if.slave  bus
);

  localparam int L      = 6 + NUM_DIGITS;
  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int BASE   = ROW * 80 + COL;
  localparam int CNT_W  = $clog2((BIN_W > L ? BIN_W : L) + 1);
  localparam logic [47:0] LABEL = "SCORE ";

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] SAT_LIMIT = pow10(NUM_DIGITS);

  typedef enum logic [2:0] {START, IDLE, CONVERT, WRITE, FINISH} state_t;

  state_t             state_reg;
  logic               pending_reg;
  logic               sat_reg;
  logic               nz_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [BCD_W-1:0]   bcd_adj;
  logic [3:0]         cur_nib;
  logic               digit_blank;
  logic [7:0]         char_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dabble
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  // During WRITE the BCD register shifts left one nibble per digit, so the
  // digit being emitted is always the top nibble.
  always_comb begin
    cur_nib     = sat_reg ? 4'd9 : bcd_reg[BCD_W-1 -: 4];
    digit_blank = (cur_nib == 4'd0) && !nz_reg && (cnt_reg != CNT_W'(L - 1));
    if (cnt_reg < CNT_W'(6))
      char_next = LABEL[8*(5 - int'(cnt_reg)) +: 8];
    else if (digit_blank)
      char_next = 8'h20;
    else
      char_next = {4'h3, cur_nib};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg         <= START;
      pending_reg       <= 1'b0;
      sat_reg           <= 1'b0;
      nz_reg            <= 1'b0;
      bin_reg           <= '0;
      bcd_reg           <= '0;
      cnt_reg           <= '0;
      bus.we            <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.data_In       <= '0;
      bus.write_address <= '0;
    end else begin
      case (state_reg)
        START, IDLE: begin
          bus.done <= 1'b0;
          bus.we   <= 1'b0;
          if (state_reg == START || bus.update || pending_reg) begin
            bin_reg     <= bus.score;
            bcd_reg     <= '0;
            sat_reg     <= (64'(bus.score) >= SAT_LIMIT);
            nz_reg      <= 1'b0;
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
            bus.busy    <= 1'b1;
            state_reg   <= CONVERT;
          end
        end
        CONVERT: begin
          if (bus.update) pending_reg <= 1'b1;
          bcd_reg <= (bcd_adj << 1) | BCD_W'(bin_reg[BIN_W-1]);
          bin_reg <= bin_reg << 1;
          if (cnt_reg == CNT_W'(BIN_W - 1)) begin
            cnt_reg   <= '0;
            state_reg <= WRITE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        WRITE: begin
          if (bus.update) pending_reg <= 1'b1;
          if (cnt_reg == CNT_W'(L)) begin
            bus.we    <= 1'b0;
            bus.done  <= 1'b1;
            bus.busy  <= 1'b0;
            state_reg <= FINISH;
          end else begin
            bus.we            <= 1'b1;
            bus.data_In       <= char_next;
            bus.write_address <= ADDR_W'(BASE) + ADDR_W'(cnt_reg);
            cnt_reg           <= cnt_reg + CNT_W'(1);
            if (cnt_reg >= CNT_W'(6)) begin
              bcd_reg <= bcd_reg << 4;
              if (cur_nib != 4'd0) nz_reg <= 1'b1;
            end
          end
        end
        FINISH: begin
          if (bus.update) pending_reg <= 1'b1;
          bus.done  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_text_writer.sv
// Scoreboard bench for score_text_writer: a monitor records every RAM write and
// done pulse; each test pushes the expected line and compares it in order.
module tb_score_text_writer;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic Clk;
  logic Reset;
  int   cyc = 0;

  wr_t got_q[$];
  wr_t gotb_q[$];
  wr_t exp_q[$];
  wr_t expb_q[$];
  int  done_q[$];
  int  we_bad = 0;
  int  busy_bad = 0;

  int checks = 0;
  int failures = 0;
  int rd = 0;
  int drd = 0;
  int t0 = 0;

  score_text_writer_if #(.BIN_W(17), .ADDR_W(8)) bus ();
  score_text_writer_if #(.BIN_W(17), .ADDR_W(8)) busb ();

  score_text_writer #(.BIN_W(17), .NUM_DIGITS(5), .ROW(0), .COL(0), .ADDR_W(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  score_text_writer #(.BIN_W(17), .NUM_DIGITS(5), .ROW(1), .COL(69), .ADDR_W(8)) dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (busb)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (bus.we)  got_q.push_back('{int'(bus.write_address), int'(bus.data_In), cyc});
    if (busb.we) gotb_q.push_back('{int'(busb.write_address), int'(busb.data_In), cyc});
    if (bus.done) done_q.push_back(cyc);
    if ((bus.we && !bus.busy) || (busb.we && !busb.busy)) we_bad++;
    if ((bus.done && bus.busy) || (busb.done && busb.busy)) busy_bad++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  // Reference line: decimal digits by division, leading zeros blanked.
  task automatic push_pass(input int unsigned sc, input int base, input int start, input bit to_b);
    int lbl[6] = '{8'h53, 8'h43, 8'h4F, 8'h52, 8'h45, 8'h20};
    int digs[5];
    int unsigned v;
    bit nz;
    wr_t e;
    v = (sc > 99999) ? 99999 : sc;
    for (int i = 4; i >= 0; i--) begin
      digs[i] = int'(v % 10);
      v = v / 10;
    end
    nz = 1'b0;
    for (int i = 0; i < 11; i++) begin
      e.addr = base + i;
      e.cyc  = start + 18 + i;
      if (i < 6) begin
        e.data = lbl[i];
      end else begin
        if (digs[i-6] != 0 || i == 10) nz = 1'b1;
        e.data = nz ? 8'h30 + digs[i-6] : 8'h20;
      end
      if (to_b) expb_q.push_back(e);
      else      exp_q.push_back(e);
    end
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int k = 0; k < budget && got_q.size() < rd + n; k++) step();
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_q.size() <= drd; k++) step();
  endtask

  task automatic pulse_update(input int unsigned sc);
    bus.score  = 17'(sc);
    bus.update = 1'b1;
    t0 = cyc + 1;
    step();
    bus.update = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) step();
    checks++; if (bus.we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", bus.we); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.data_In !== 8'h00) begin failures++; $display("FAIL reset_data: got %02h expected 00", bus.data_In); end
    checks++; if (bus.write_address !== 8'h00) begin failures++; $display("FAIL reset_addr: got %0d expected 0", bus.write_address); end
    Reset = 1'b0;
    t0 = cyc + 1;
    push_pass(0, 0, t0, 1'b0);
    push_pass(42, 149, t0, 1'b1);
    $display("reset released, start pass accept edge %0d", t0);
  endtask

  task automatic test_start_pass();
    int dv;
    wait_got(11, 100);
    for (int i = 0; i < 11; i++) begin
      wr_t e, g;
      e = exp_q.pop_front();
      g = (rd < got_q.size()) ? got_q[rd] : '{-1, -1, -1};
      rd++;
      checks++;
      if (g.addr !== e.addr || g.data !== e.data || g.cyc !== e.cyc) begin
        failures++;
        $display("FAIL start_pass[%0d]: got addr=%0d data=%02h cyc=%0d expected addr=%0d data=%02h cyc=%0d",
                 i, g.addr, g.data, g.cyc, e.addr, e.data, e.cyc);
      end else $display("start_pass[%0d] addr=%0d data=%02h cyc=%0d ok", i, g.addr, g.data, g.cyc);
    end
    wait_done(100);
    dv = (drd < done_q.size()) ? done_q[drd] : -1;
    drd++;
    checks++;
    if (dv !== t0 + 29) begin failures++; $display("FAIL start_done: got cycle %0d expected %0d", dv, t0 + 29); end
    else $display("start_done cycle %0d ok", dv);
    repeat (2) step();
  endtask

  task automatic test_digits();
    int dv;
    pulse_update(1234);
    push_pass(1234, 0, t0, 1'b0);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL digits_busy: got %b expected 1", bus.busy); end
    wait_got(11, 100);
    for (int i = 0; i < 11; i++) begin
      wr_t e, g;
      e = exp_q.pop_front();
      g = (rd < got_q.size()) ? got_q[rd] : '{-1, -1, -1};
      rd++;
      checks++;
      if (g.addr !== e.addr || g.data !== e.data || g.cyc !== e.cyc) begin
        failures++;
        $display("FAIL digits[%0d]: got addr=%0d data=%02h cyc=%0d expected addr=%0d data=%02h cyc=%0d",
                 i, g.addr, g.data, g.cyc, e.addr, e.data, e.cyc);
      end else $display("digits[%0d] addr=%0d data=%02h ok", i, g.addr, g.data);
    end
    wait_done(100);
    dv = (drd < done_q.size()) ? done_q[drd] : -1;
    drd++;
    checks++;
    if (dv !== t0 + 29) begin failures++; $display("FAIL digits_done: got cycle %0d expected %0d", dv, t0 + 29); end
    repeat (2) step();
  endtask

  task automatic test_saturation();
    int unsigned scores[5] = '{131071, 100000, 99999, 10005, 10};
    int dv;
    foreach (scores[s]) begin
      pulse_update(scores[s]);
      push_pass(scores[s], 0, t0, 1'b0);
      wait_got(11, 100);
      for (int i = 0; i < 11; i++) begin
        wr_t e, g;
        e = exp_q.pop_front();
        g = (rd < got_q.size()) ? got_q[rd] : '{-1, -1, -1};
        rd++;
        checks++;
        if (g.addr !== e.addr || g.data !== e.data || g.cyc !== e.cyc) begin
          failures++;
          $display("FAIL sat_%0d[%0d]: got addr=%0d data=%02h cyc=%0d expected addr=%0d data=%02h cyc=%0d",
                   scores[s], i, g.addr, g.data, g.cyc, e.addr, e.data, e.cyc);
        end else $display("sat_%0d[%0d] data=%02h ok", scores[s], i, g.data);
      end
      wait_done(100);
      dv = (drd < done_q.size()) ? done_q[drd] : -1;
      drd++;
      checks++;
      if (dv !== t0 + 29) begin failures++; $display("FAIL sat_%0d_done: got cycle %0d expected %0d", scores[s], dv, t0 + 29); end
      repeat (2) step();
    end
  endtask

  task automatic test_pending();
    int dv;
    int t_first;
    pulse_update(500);
    t_first = t0;
    push_pass(500, 0, t_first, 1'b0);
    push_pass(7, 0, t_first + 31, 1'b0);
    repeat (5) step();
    bus.update = 1'b1; step(); bus.update = 1'b0;
    repeat (15) step();
    bus.score = 17'd7;
    bus.update = 1'b1; step(); bus.update = 1'b0;
    repeat (2) step();
    bus.update = 1'b1; step(); bus.update = 1'b0;
    wait_got(22, 200);
    for (int i = 0; i < 22; i++) begin
      wr_t e, g;
      e = exp_q.pop_front();
      g = (rd < got_q.size()) ? got_q[rd] : '{-1, -1, -1};
      rd++;
      checks++;
      if (g.addr !== e.addr || g.data !== e.data || g.cyc !== e.cyc) begin
        failures++;
        $display("FAIL pending[%0d]: got addr=%0d data=%02h cyc=%0d expected addr=%0d data=%02h cyc=%0d",
                 i, g.addr, g.data, g.cyc, e.addr, e.data, e.cyc);
      end else $display("pending[%0d] addr=%0d data=%02h cyc=%0d ok", i, g.addr, g.data, g.cyc);
    end
    for (int p = 0; p < 2; p++) begin
      wait_done(100);
      dv = (drd < done_q.size()) ? done_q[drd] : -1;
      drd++;
      checks++;
      if (dv !== t_first + 29 + 31 * p) begin
        failures++;
        $display("FAIL pending_done%0d: got cycle %0d expected %0d", p, dv, t_first + 29 + 31 * p);
      end
    end
    repeat (60) step();
    checks++;
    if (got_q.size() !== rd) begin failures++; $display("FAIL pending_extra_writes: got %0d expected 0", got_q.size() - rd); end
    checks++;
    if (done_q.size() !== drd) begin failures++; $display("FAIL pending_extra_done: got %0d expected 0", done_q.size() - drd); end
  endtask

  task automatic test_reset_mid_write();
    int dv;
    int lbl[3] = '{8'h53, 8'h43, 8'h4F};
    pulse_update(2468);
    for (int i = 0; i < 3; i++) exp_q.push_back('{i, lbl[i], t0 + 18 + i});
    wait_got(3, 100);
    Reset = 1'b1;
    #1;
    checks++;
    if (bus.we !== 1'b0) begin failures++; $display("FAIL midreset_we: got %b expected 0", bus.we); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
    repeat (2) step();
    Reset = 1'b0;
    t0 = cyc + 1;
    push_pass(2468, 0, t0, 1'b0);
    wait_got(14, 100);
    for (int i = 0; i < 14; i++) begin
      wr_t e, g;
      e = exp_q.pop_front();
      g = (rd < got_q.size()) ? got_q[rd] : '{-1, -1, -1};
      rd++;
      checks++;
      if (g.addr !== e.addr || g.data !== e.data || g.cyc !== e.cyc) begin
        failures++;
        $display("FAIL midreset[%0d]: got addr=%0d data=%02h cyc=%0d expected addr=%0d data=%02h cyc=%0d",
                 i, g.addr, g.data, g.cyc, e.addr, e.data, e.cyc);
      end else $display("midreset[%0d] addr=%0d data=%02h ok", i, g.addr, g.data);
    end
    wait_done(100);
    dv = (drd < done_q.size()) ? done_q[drd] : -1;
    drd++;
    checks++;
    if (dv !== t0 + 29) begin failures++; $display("FAIL midreset_done: got cycle %0d expected %0d", dv, t0 + 29); end
    repeat (2) step();
  endtask

  task automatic test_offset_row();
    for (int i = 0; i < 11; i++) begin
      wr_t e, g;
      e = expb_q.pop_front();
      g = (i < gotb_q.size()) ? gotb_q[i] : '{-1, -1, -1};
      checks++;
      if (g.addr !== e.addr || g.data !== e.data || g.cyc !== e.cyc) begin
        failures++;
        $display("FAIL offset[%0d]: got addr=%0d data=%02h cyc=%0d expected addr=%0d data=%02h cyc=%0d",
                 i, g.addr, g.data, g.cyc, e.addr, e.data, e.cyc);
      end else $display("offset[%0d] addr=%0d data=%02h ok", i, g.addr, g.data);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (we_bad !== 0) begin failures++; $display("FAIL we_while_idle: got %0d cycles expected 0", we_bad); end
    checks++;
    if (busy_bad !== 0) begin failures++; $display("FAIL busy_with_done: got %0d cycles expected 0", busy_bad); end
  endtask

  initial begin
    Reset       = 1'b1;
    bus.score   = '0;
    bus.update  = 1'b0;
    busb.score  = 17'd42;
    busb.update = 1'b0;
    test_reset();
    test_start_pass();
    test_digits();
    test_saturation();
    test_pending();
    test_reset_mid_write();
    test_offset_row();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
